scope_capture: RTL and testbench

Triggered capture buffer directly downstream of the ADC sampling stage. Consumes the 8-bit sample stream and its one-cycle valid strobe (10 MS/s at a 100 MHz `iCLK`). Stores samples in an on-chip ring buffer around a programmable edge trigger, then plays the captured window back, oldest first, through a request/response read port feeding the host-link stage.

---
 rtl/scope_pkg.sv | 16 +
 rtl/scope_capture_if.sv | 33 +++
 rtl/scope_sample_ram.sv | 30 +++
 rtl/scope_capture.sv | 144 ++++++++++++++
 tb/tb_scope_capture.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/scope_pkg.sv
// Shared definitions for the triggered capture buffer: default geometry and
// the capture state encoding.
package scope_pkg;

  localparam int P_ADDR_BITS = 10;
  localparam int P_DATA_BITS = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRE       = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POST      = 3'd3,
    S_DONE      = 3'd4
  } state_t;

endpackage

// File: rtl/scope_capture_if.sv
// Sample, control and readout signals of the capture buffer. The master side
// drives the sample stream and control pulses; the slave side is the buffer.
interface scope_capture_if #(
  parameter int pAddrBits = scope_pkg::P_ADDR_BITS,
  parameter int pDataBits = scope_pkg::P_DATA_BITS
);

  logic [pDataBits-1:0] iSample_Data;
  logic                 iSample_Valid;
  logic                 iArm;
  logic [pDataBits-1:0] iTrig_Level;
  logic                 iTrig_Rising;
  logic [pAddrBits-1:0] iPre_Trig;
  logic                 iForce_Trig;
  logic                 iRd_Req;
  logic [pDataBits-1:0] oRd_Data;
  logic                 oRd_Valid;
  logic                 oBusy;
  logic                 oDone;

  modport master (
    output iSample_Data, iSample_Valid, iArm, iTrig_Level, iTrig_Rising,
           iPre_Trig, iForce_Trig, iRd_Req,
    input  oRd_Data, oRd_Valid, oBusy, oDone
  );

  modport slave (
    input  iSample_Data, iSample_Valid, iArm, iTrig_Level, iTrig_Rising,
           iPre_Trig, iForce_Trig, iRd_Req,
    output oRd_Data, oRd_Valid, oBusy, oDone
  );

endinterface

// File: rtl/scope_sample_ram.sv
// Simple dual-port sample store: one synchronous write port and one
// synchronous read port with a registered output (block-RAM friendly).
module scope_sample_ram #(
  parameter int pAddrBits = scope_pkg::P_ADDR_BITS,
  parameter int pDataBits = scope_pkg::P_DATA_BITS
) (
  input  logic                 iCLK,
  input  logic                 i_wr_en,
  input  logic [pAddrBits-1:0] i_wr_addr,
  input  logic [pDataBits-1:0] i_wr_data,
  input  logic                 i_rd_en,
  input  logic [pAddrBits-1:0] i_rd_addr,
  output logic [pDataBits-1:0] o_rd_data
);

  logic [pDataBits-1:0] r_mem [0:(2**pAddrBits)-1];
  logic [pDataBits-1:0] r_rd_data;

  // Write the incoming sample and register the addressed read word.
  // NOTE: the array and its read register carry no reset; a reset would
  // prevent mapping onto block RAM, and stale contents are never exposed
  // because the readout path is qualified by a reset-cleared valid flag.
  always_ff @(posedge iCLK) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/scope_capture.sv
// Triggered capture buffer: writes the sample stream into a ring, detects a
// level-crossing (or forced) trigger, keeps a window of pre-trigger history
// plus post-trigger samples, then plays the window back oldest first.
module scope_capture
  import scope_pkg::*;
#(
  parameter int pAddrBits = P_ADDR_BITS,
  parameter int pDataBits = P_DATA_BITS
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  scope_capture_if.slave bus
);

  localparam int                   LP_DEPTH   = 2 ** pAddrBits;
  localparam logic [pAddrBits-1:0] LP_A_ONE   = pAddrBits'(1);
  localparam logic [pAddrBits:0]   LP_P_ONE   = (pAddrBits + 1)'(1);
  localparam logic [pAddrBits:0]   LP_DEPTH_P = (pAddrBits + 1)'(LP_DEPTH);

  state_t               r_state, w_state_nxt;
  logic [pAddrBits-1:0] r_wr_ptr, r_pre_cnt, r_pre, r_start, r_rd_cnt;
  logic [pAddrBits:0]   r_post_cnt;
  logic [pDataBits-1:0] r_level, r_prev_data;
  logic                 r_rising, r_prev_valid, r_force_pend, r_rd_valid;

  logic                 w_store, w_trig, w_trig_cond, w_rd_en;
  logic [pAddrBits:0]   w_post_target;
  logic [pAddrBits-1:0] w_rd_addr;
  logic [pDataBits-1:0] w_ram_q;

  // The port is pAddrBits wide, so a pre count of depth or more cannot be
  // presented; the largest encodable value is already depth - 1.
  assign w_post_target = LP_DEPTH_P - {1'b0, r_pre};
  assign w_rd_addr     = r_start + r_rd_cnt;

  // Next-state, store/trigger/read decisions for the current cycle.
  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch; combinational
  // logic uses blocking '=' while clocked state below uses '<='.
  always_comb begin
    w_state_nxt = r_state;
    w_store     = 1'b0;
    w_trig      = 1'b0;
    w_rd_en     = 1'b0;
    w_trig_cond = 1'b0;
    if (r_prev_valid) begin
      if (r_rising) w_trig_cond = (r_prev_data < r_level) && (bus.iSample_Data >= r_level);
      else          w_trig_cond = (r_prev_data > r_level) && (bus.iSample_Data <= r_level);
    end
    if (bus.iArm) begin
      w_state_nxt = (bus.iPre_Trig == '0) ? S_WAIT_TRIG : S_PRE;
    end else begin
      case (r_state)
        S_PRE: begin
          w_store = bus.iSample_Valid;
          if (w_store && ((r_pre_cnt + LP_A_ONE) == r_pre)) w_state_nxt = S_WAIT_TRIG;
        end
        S_WAIT_TRIG: begin
          w_store = bus.iSample_Valid;
          if (w_store && (r_force_pend || bus.iForce_Trig || w_trig_cond)) begin
            w_trig      = 1'b1;
            w_state_nxt = (w_post_target == LP_P_ONE) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          w_store = bus.iSample_Valid;
          if (w_store && ((r_post_cnt + LP_P_ONE) == w_post_target)) w_state_nxt = S_DONE;
        end
        S_DONE: begin
          w_rd_en = bus.iRd_Req;
          if (w_rd_en && (r_rd_cnt == '1)) w_state_nxt = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // State register, pointers, counters and the latched trigger settings.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_pre_cnt    <= '0;
      r_post_cnt   <= '0;
      r_rd_cnt     <= '0;
      r_start      <= '0;
      r_pre        <= '0;
      r_level      <= '0;
      r_rising     <= 1'b0;
      r_prev_data  <= '0;
      r_prev_valid <= 1'b0;
      r_force_pend <= 1'b0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_valid <= w_rd_en;
      if (bus.iArm) begin
        r_wr_ptr     <= '0;
        r_pre_cnt    <= '0;
        r_post_cnt   <= '0;
        r_rd_cnt     <= '0;
        r_prev_valid <= 1'b0;
        r_force_pend <= 1'b0;
        r_level      <= bus.iTrig_Level;
        r_rising     <= bus.iTrig_Rising;
        r_pre        <= bus.iPre_Trig;
      end else begin
        if (w_store) begin
          r_wr_ptr     <= r_wr_ptr + LP_A_ONE;
          r_prev_data  <= bus.iSample_Data;
          r_prev_valid <= 1'b1;
        end
        if (w_store && (r_state == S_PRE))  r_pre_cnt  <= r_pre_cnt + LP_A_ONE;
        if (w_store && (r_state == S_POST)) r_post_cnt <= r_post_cnt + LP_P_ONE;
        if ((r_state == S_WAIT_TRIG) && bus.iForce_Trig && !w_trig) r_force_pend <= 1'b1;
        if (w_trig) begin
          r_start      <= r_wr_ptr - r_pre;
          r_post_cnt   <= LP_P_ONE;
          r_force_pend <= 1'b0;
        end
        if (w_rd_en) r_rd_cnt <= r_rd_cnt + LP_A_ONE;
      end
    end
  end

  scope_sample_ram #(
    .pAddrBits (pAddrBits),
    .pDataBits (pDataBits)
  ) u_ram (
    .iCLK      (iCLK),
    .i_wr_en   (w_store),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (bus.iSample_Data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_ram_q)
  );

  assign bus.oRd_Valid = r_rd_valid;
  assign bus.oRd_Data  = r_rd_valid ? w_ram_q : '0;
  assign bus.oBusy     = (r_state == S_PRE) || (r_state == S_WAIT_TRIG) || (r_state == S_POST);
  assign bus.oDone     = (r_state == S_DONE);

endmodule

// File: tb/tb_scope_capture.sv
// Bench for scope_capture at depth 16. A behavioural model keeps the list of
// samples stored since arm, finds the trigger index from the edge rules and
// slices the expected window out of that list; read requests push expected
// words into a scoreboard queue that a separate monitor drains.
module tb_scope_capture;

  localparam int A     = 4;
  localparam int D     = 8;
  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;

  scope_capture_if #(.pAddrBits(A), .pDataBits(D)) bus ();

  scope_capture #(.pAddrBits(A), .pDataBits(D)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model state
  logic [7:0] hist[$];
  logic [7:0] exp_q[$];
  int         m_trig;
  int         m_pre;
  logic [7:0] m_level;
  bit         m_rising;
  bit         m_armed;
  bit         m_force_pend;
  int         m_reads;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit m_done();
    return m_armed && (m_trig >= 0) && (hist.size() >= m_trig + DEPTH - m_pre);
  endfunction

  function automatic bit edge_hit(input logic [7:0] prev, input logic [7:0] cur);
    if (m_rising) return (prev < m_level) && (cur >= m_level);
    return (prev > m_level) && (cur <= m_level);
  endfunction

  task automatic check_status(input string tag);
    check({tag, "_busy"}, 32'(bus.oBusy), 32'(m_armed && !m_done()));
    check({tag, "_done"}, 32'(bus.oDone), 32'(m_done()));
  endtask

  // Monitor: every presented readout word must match the oldest expectation.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n && bus.oRd_Valid) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 32'(bus.oRd_Valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", 32'(bus.oRd_Data), 32'(e));
      end
    end
  end

  task automatic arm(input logic [7:0] level, input bit rising, input int pre,
                     input bit with_sample, input bit with_read);
    @(posedge clk); #1;
    bus.iArm          = 1'b1;
    bus.iTrig_Level   = level;
    bus.iTrig_Rising  = rising;
    bus.iPre_Trig     = 4'(pre);
    bus.iSample_Valid = with_sample;
    bus.iSample_Data  = 8'hFF;
    bus.iRd_Req       = with_read;
    hist.delete();
    m_trig = -1; m_pre = pre; m_level = level; m_rising = rising;
    m_armed = 1'b1; m_force_pend = 1'b0; m_reads = 0;
    @(posedge clk); #1;
    bus.iArm = 1'b0; bus.iSample_Valid = 1'b0; bus.iRd_Req = 1'b0;
    check_status("arm");
  endtask

  task automatic send_sample(input logic [7:0] d);
    int i;
    @(posedge clk); #1;
    bus.iSample_Data  = d;
    bus.iSample_Valid = 1'b1;
    if (m_armed && !m_done()) begin
      i = hist.size();
      hist.push_back(d);
      if (m_trig < 0 && i >= m_pre &&
          (m_force_pend || (i >= 1 && edge_hit(hist[i-1], d)))) begin
        m_trig = i;
        m_force_pend = 1'b0;
      end
    end
    @(posedge clk); #1;
    bus.iSample_Valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_status("sample");
  endtask

  task automatic force_trig();
    @(posedge clk); #1;
    bus.iForce_Trig = 1'b1;
    if (m_armed && m_trig < 0 && hist.size() >= m_pre) m_force_pend = 1'b1;
    @(posedge clk); #1;
    bus.iForce_Trig = 1'b0;
  endtask

  task automatic model_read();
    if (m_done() && m_reads < DEPTH) begin
      exp_q.push_back(hist[m_trig - m_pre + m_reads]);
      m_reads++;
      if (m_reads == DEPTH) m_armed = 1'b0;
    end
  endtask

  // Hold iRd_Req for n consecutive cycles.
  task automatic read_burst(input int n);
    @(posedge clk); #1;
    bus.iRd_Req = 1'b1;
    model_read();
    for (int k = 1; k < n; k++) begin
      @(posedge clk); #1;
      check_status("read");
      model_read();
    end
    @(posedge clk); #1;
    bus.iRd_Req = 1'b0;
    check_status("read");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_until_done(input int base, input int step, input int limit);
    for (int k = 0; k < limit && !m_done(); k++) send_sample(8'(base + step * k));
    check("capture_done", 32'(bus.oDone), 32'd1);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.iSample_Data = '0; bus.iSample_Valid = 1'b0; bus.iArm = 1'b0;
    bus.iTrig_Level = '0; bus.iTrig_Rising = 1'b0; bus.iPre_Trig = '0;
    bus.iForce_Trig = 1'b0; bus.iRd_Req = 1'b0;
    m_armed = 1'b0; m_trig = -1; m_pre = 0; m_reads = 0; m_force_pend = 1'b0;
    m_level = '0; m_rising = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  32'(bus.oRd_Data),  32'd0);
    check("rst_valid", 32'(bus.oRd_Valid), 32'd0);
    check("rst_busy",  32'(bus.oBusy),     32'd0);
    check("rst_done",  32'(bus.oDone),     32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Read request while idle is ignored.
    read_burst(2);

    // Reset asserted mid-POST.
    arm(8'h80, 1'b1, 4, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) send_sample(8'(8 * k));
    check("post_busy", 32'(bus.oBusy), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    m_armed = 1'b0;
    #1;
    check("rst2_data",  32'(bus.oRd_Data),  32'd0);
    check("rst2_valid", 32'(bus.oRd_Valid), 32'd0);
    check("rst2_busy",  32'(bus.oBusy),     32'd0);
    check("rst2_done",  32'(bus.oDone),     32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    read_burst(1);

    // Rising trigger on a ramp: window 0x60..0xD8, back-to-back reads.
    arm(8'h80, 1'b1, 4, 1'b0, 1'b0);
    run_until_done(0, 8, 40);
    read_burst(DEPTH);

    // Falling trigger: 0x90 x10 then 0x30 x20, single reads.
    arm(8'h40, 1'b0, 2, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) send_sample(8'h90);
    for (int k = 0; k < 20; k++) send_sample(8'h30);
    for (int k = 0; k < DEPTH; k++) read_burst(1);

    // pre = 0: 0x00 then 0x10, 0x11, ...
    arm(8'h10, 1'b1, 0, 1'b0, 1'b0);
    send_sample(8'h00);
    run_until_done(16, 1, 40);
    read_burst(DEPTH);

    // pre = 0: first sample above level must not trigger.
    arm(8'h10, 1'b1, 0, 1'b0, 1'b0);
    send_sample(8'h20);
    send_sample(8'h30);
    check("no_first_trig", 32'(bus.oBusy), 32'd1);
    send_sample(8'h05);
    run_until_done(8'h15, 1, 40);
    read_burst(DEPTH);

    // Force trigger on a flat signal; the force in PRE is ignored.
    arm(8'h80, 1'b1, 8, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send_sample(8'h55);
    force_trig();
    for (int k = 0; k < 7; k++) send_sample(8'h55);
    check("force_pre_ignored", 32'(bus.oBusy), 32'd1);
    force_trig();
    run_until_done(8'h55, 0, 40);
    read_burst(DEPTH);

    // Re-arm mid-POST (with a coincident sample), then mid-readout (with a
    // coincident read request).
    arm(8'h80, 1'b1, 4, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) send_sample(8'(8 * k));
    arm(8'h40, 1'b1, 3, 1'b1, 1'b0);
    run_until_done(8'h20, 2, 40);
    read_burst(5);
    arm(8'h80, 1'b0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) send_sample(8'hF0);
    run_until_done(8'h10, 0, 40);
    read_burst(DEPTH);

    // Randomized captures.
    for (int it = 0; it < 6; it++) begin
      arm(8'($urandom_range(32, 223)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 15)), 1'b0, 1'b0);
      for (int s = 0; s < 60 && !m_done(); s++) begin
        if (s == 30 && m_trig < 0) force_trig();
        send_sample(8'($urandom_range(0, 255)));
      end
      check("rand_done", 32'(bus.oDone), 32'd1);
      for (int g = 0; g < 20 && m_armed; g++) begin
        read_burst(int'($urandom_range(1, 4)));
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end

    repeat (5) @(posedge clk);
    #1;
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
